// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback controller:
// opcodes, instruction field positions, flag order and FSM states.
package alu_pkg;

  localparam logic [7:0] OP_LD  = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_SUB = 8'h04;
  localparam logic [7:0] OP_AND = 8'h05;
  localparam logic [7:0] OP_OR  = 8'h06;
  localparam logic [7:0] OP_XOR = 8'h07;
  localparam logic [7:0] OP_NOT = 8'h08;
  localparam logic [7:0] OP_SL  = 8'h09;
  localparam logic [7:0] OP_SR  = 8'h0A;

  localparam int OP_LO   = 24;
  localparam int RD_LO   = 21;
  localparam int RA_LO   = 18;
  localparam int RB_LO   = 15;
  localparam int IMM_SEL = 14;
  localparam int IMM_W   = 14;

  // flags_q = {z,n,c,v,s,h}
  localparam int FLG_Z = 5;
  localparam int FLG_N = 4;
  localparam int FLG_C = 3;
  localparam int FLG_V = 2;
  localparam int FLG_S = 1;
  localparam int FLG_H = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  function automatic logic op_legal(input logic [7:0] op);
    return op inside {OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR,
                      OP_XOR, OP_NOT, OP_SL, OP_SR};
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two operand read ports, one debug read port,
// one synchronous write port; r0 is hardwired to zero.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     i_ra_addr,
  output logic [DATA_W-1:0] o_ra_data,
  input  logic [AW-1:0]     i_rb_addr,
  output logic [DATA_W-1:0] o_rb_data,
  input  logic [AW-1:0]     i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data,
  input  logic              i_we,
  input  logic [AW-1:0]     i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [DATA_W-1:0] r_mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_ra_data  = r_mem[i_ra_addr];
  assign o_rb_data  = r_mem[i_rb_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller: accepts an instruction, drives the ALU,
// waits its latency, then writes the result back and latches flags.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [31:0]              instr,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [7:0]               alu_op,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic                     alu_z,
  input  logic                     alu_n,
  input  logic                     alu_c,
  input  logic                     alu_v,
  input  logic                     alu_s,
  input  logic                     alu_h,
  output logic [5:0]               flags_q,
  output logic                     wb_valid,
  output logic [$clog2(NREGS)-1:0] wb_rd,
  output logic [DATA_W-1:0]        wb_data,
  output logic                     illegal,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = 2;
  localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [AW-1:0]     r_rd;
  logic              r_ready;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [7:0]        r_alu_op;
  logic [5:0]        r_flags;
  logic              r_wb_valid;
  logic [AW-1:0]     r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_illegal;

  logic [7:0]        w_op;
  logic [AW-1:0]     w_rd;
  logic [AW-1:0]     w_ra;
  logic [AW-1:0]     w_rb;
  logic [DATA_W-1:0] w_ra_data;
  logic [DATA_W-1:0] w_rb_data;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_b;
  logic              w_accept;
  logic              w_we;

  assign w_op     = instr[OP_LO +: 8];
  assign w_rd     = instr[RD_LO +: AW];
  assign w_ra     = instr[RA_LO +: AW];
  assign w_rb     = instr[RB_LO +: AW];
  assign w_imm    = {{(DATA_W-IMM_W){1'b0}}, instr[IMM_W-1:0]};
  assign w_b      = instr[IMM_SEL] ? w_imm : w_rb_data;
  assign w_accept = instr_valid && r_ready;
  assign w_we     = (r_state == S_WB);

  alu_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ra_addr (w_ra),
    .o_ra_data (w_ra_data),
    .i_rb_addr (w_rb),
    .o_rb_data (w_rb_data),
    .i_dbg_addr(dbg_addr),
    .o_dbg_data(dbg_data),
    .i_we      (w_we),
    .i_wa      (r_rd),
    .i_wd      (alu_out)
  );

  // Operands are registered at accept so they sit on the bus for all of ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_ready    <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_flags    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (op_legal(w_op)) begin
              r_ready  <= 1'b0;
              r_state  <= S_ISSUE;
              r_alu_a  <= w_ra_data;
              r_alu_b  <= w_b;
              r_alu_op <= w_op;
              r_rd     <= w_rd;
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= CNT_INIT;
          r_state <= (ALU_LAT == 1) ? S_WB : S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= S_WB;
        end
        S_WB: begin
          r_flags[FLG_Z] <= alu_z;
          r_flags[FLG_N] <= alu_n;
          r_flags[FLG_C] <= alu_c;
          r_flags[FLG_V] <= alu_v;
          r_flags[FLG_S] <= alu_s;
          r_flags[FLG_H] <= alu_h;
          r_wb_valid     <= 1'b1;
          r_wb_rd        <= r_rd;
          r_wb_data      <= alu_out;
          r_alu_a        <= '0;
          r_alu_b        <= '0;
          r_alu_op       <= '0;
          r_ready        <= 1'b1;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign flags_q     = r_flags;
  assign wb_valid    = r_wb_valid;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: ALU_LAT=1 instance with a scoreboard,
// plus an ALU_LAT=3 instance for latency and mid-operation reset.
module tb_alu_issue_ctrl;

  typedef struct {
    bit          ill;
    logic [2:0]  rd;
    logic [31:0] data;
    logic [5:0]  flg;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        rst_n, instr_valid, instr_ready;
  logic [31:0] instr, alu_a, alu_b, alu_out, wb_data, dbg_data;
  logic [7:0]  alu_op;
  logic        alu_z, alu_n, alu_c, alu_v, alu_s, alu_h;
  logic [5:0]  flags_q;
  logic        wb_valid, illegal;
  logic [2:0]  wb_rd, dbg_addr;

  logic        rst3_n, instr_valid3, instr_ready3;
  logic [31:0] instr3, alu_a3, alu_b3, alu_out3, wb_data3, dbg_data3;
  logic [7:0]  alu_op3;
  logic        alu_z3, alu_n3, alu_c3, alu_v3, alu_s3, alu_h3;
  logic [5:0]  flags_q3;
  logic        wb_valid3, illegal3;
  logic [2:0]  wb_rd3, dbg_addr3;

  alu_issue_ctrl #(.DATA_W(32), .NREGS(8), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c),
    .alu_v(alu_v), .alu_s(alu_s), .alu_h(alu_h),
    .flags_q(flags_q), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  alu_issue_ctrl #(.DATA_W(32), .NREGS(8), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .instr_valid(instr_valid3), .instr_ready(instr_ready3), .instr(instr3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_out(alu_out3),
    .alu_z(alu_z3), .alu_n(alu_n3), .alu_c(alu_c3),
    .alu_v(alu_v3), .alu_s(alu_s3), .alu_h(alu_h3),
    .flags_q(flags_q3), .wb_valid(wb_valid3), .wb_rd(wb_rd3),
    .wb_data(wb_data3), .illegal(illegal3),
    .dbg_addr(dbg_addr3), .dbg_data(dbg_data3)
  );

  // Reference ALU: returns {z,n,c,v,s,h,result}
  function automatic logic [37:0] alu_f(input logic [7:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] t;
    logic [31:0] r;
    logic c, v, h, n;
    r = '0; c = 0; v = 0; h = 0; t = '0;
    case (op)
      8'h01: r = b;
      8'h03: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[31:0]; c = t[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
        h = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
      end
      8'h04: begin
        t = {1'b0, a} - {1'b0, b};
        r = t[31:0]; c = t[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
        h = a[3:0] < b[3:0];
      end
      8'h05: r = a & b;
      8'h06: r = a | b;
      8'h07: r = a ^ b;
      8'h08: r = ~a;
      8'h09: r = a << b[4:0];
      8'h0A: r = a >> b[4:0];
      default: r = '0;
    endcase
    n = r[31];
    return {(r == 32'd0), n, c, v, n ^ v, h, r};
  endfunction

  logic [37:0] p1;
  always @(posedge clk) p1 <= alu_f(alu_op, alu_a, alu_b);
  assign {alu_z, alu_n, alu_c, alu_v, alu_s, alu_h, alu_out} = p1;

  logic [37:0] p3 [3];
  always @(posedge clk) begin
    p3[0] <= alu_f(alu_op3, alu_a3, alu_b3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign {alu_z3, alu_n3, alu_c3, alu_v3, alu_s3, alu_h3, alu_out3} = p3[2];

  exp_t        sb[$];
  logic [31:0] m_regs [8];
  logic [5:0]  m_flags;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op,
                                     input logic [2:0] rd,
                                     input logic [2:0] ra,
                                     input logic [2:0] rb,
                                     input logic is,
                                     input logic [13:0] imm);
    return {op, rd, ra, rb, is, imm};
  endfunction

  task automatic dbgchk(input string tag, input logic [2:0] a,
                        input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // Drive one word, push expectation, wait for wb/illegal, pop and compare.
  task automatic send(input logic [31:0] w, output int wb_cyc);
    exp_t e, g;
    logic [37:0] f;
    logic [31:0] a, b;
    logic [7:0] op;
    int n, k;
    op = w[31:24];
    a = m_regs[w[20:18]];
    b = w[14] ? {18'b0, w[13:0]} : m_regs[w[17:15]];
    f = alu_f(op, a, b);
    e.ill  = !(op inside {8'h01, 8'h03, 8'h04, 8'h05, 8'h06,
                          8'h07, 8'h08, 8'h09, 8'h0A});
    e.rd   = w[23:21];
    e.data = f[31:0];
    e.flg  = e.ill ? m_flags : f[37:32];
    sb.push_back(e);
    if (!e.ill) begin
      if (e.rd != 3'd0) m_regs[e.rd] = f[31:0];
      m_flags = f[37:32];
    end
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", {31'b0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = '0;
    k = 0;
    while (!wb_valid && !illegal && k < 12) begin
      @(posedge clk); #1; k++;
    end
    wb_cyc = cyc;
    g = sb.pop_front();
    chk("kind_illegal", {31'b0, illegal}, {31'b0, g.ill});
    if (g.ill) begin
      chk("ill_latency", k, 0);
      chk("ill_no_wb", {31'b0, wb_valid}, 32'd0);
      chk("ill_flags", {26'b0, flags_q}, {26'b0, g.flg});
      chk("ill_ready", {31'b0, instr_ready}, 32'd1);
      @(posedge clk); #1;
      chk("ill_once", {31'b0, illegal}, 32'd0);
    end else begin
      chk("wb_latency", k, 2);
      chk("wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("wb_rd", {29'b0, wb_rd}, {29'b0, g.rd});
      chk("wb_data", wb_data, g.data);
      chk("wb_flags", {26'b0, flags_q}, {26'b0, g.flg});
    end
  endtask

  initial begin
    int c0, c1, c2;
    logic seen;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_flags = '0;
    rst_n = 0; rst3_n = 0;
    instr_valid = 0; instr = '0; dbg_addr = '0;
    instr_valid3 = 0; instr3 = '0; dbg_addr3 = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, instr_ready}, 32'd0);
    chk("rst_op", {24'b0, alu_op}, 32'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_flags", {26'b0, flags_q}, 32'd0);
    chk("rst_wb", {31'b0, wb_valid}, 32'd0);
    chk("rst_ill", {31'b0, illegal}, 32'd0);
    dbgchk("rst_dbg", 3'd1, 32'd0);
    rst_n = 1; rst3_n = 1;
    chk("rel_ready0", {31'b0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel_ready1", {31'b0, instr_ready}, 32'd1);

    send(mk(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 14'h3FFF), c0);
    chk("ld_z", {31'b0, flags_q[5]}, 32'd0);
    dbgchk("ld_dbg", 3'd1, 32'h0000_3FFF);

    send(mk(8'h01, 3'd2, 3'd0, 3'd0, 1'b1, 14'h0001), c0);
    send(mk(8'h03, 3'd3, 3'd0, 3'd2, 1'b0, 14'h0), c0);
    dbgchk("add_r3", 3'd3, 32'd1);
    send(mk(8'h08, 3'd4, 3'd0, 3'd0, 1'b0, 14'h0), c0);
    dbgchk("not_r4", 3'd4, 32'hFFFF_FFFF);
    send(mk(8'h03, 3'd5, 3'd4, 3'd2, 1'b0, 14'h0), c0);
    chk("wrap_data", wb_data, 32'd0);
    chk("wrap_z", {31'b0, flags_q[5]}, 32'd1);
    chk("wrap_c", {31'b0, flags_q[3]}, 32'd1);

    send(mk(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 14'd5), c0);
    send(mk(8'h03, 3'd1, 3'd1, 3'd0, 1'b1, 14'd3), c1);
    send(mk(8'h03, 3'd1, 3'd1, 3'd0, 1'b1, 14'd3), c2);
    chk("chain_gap1", c1 - c0, 3);
    chk("chain_gap2", c2 - c1, 3);
    chk("chain_data", wb_data, 32'h0000_000B);
    dbgchk("chain_r1", 3'd1, 32'h0000_000B);

    send(mk(8'h04, 3'd6, 3'd2, 3'd1, 1'b0, 14'h0), c0);
    send(mk(8'h05, 3'd6, 3'd1, 3'd0, 1'b1, 14'h0F0A), c0);
    send(mk(8'h06, 3'd6, 3'd1, 3'd4, 1'b0, 14'h0), c0);
    send(mk(8'h07, 3'd7, 3'd1, 3'd0, 1'b1, 14'h2AAA), c0);
    send(mk(8'h09, 3'd7, 3'd1, 3'd0, 1'b1, 14'd4), c0);
    send(mk(8'h0A, 3'd7, 3'd4, 3'd0, 1'b1, 14'd28), c0);
    dbgchk("sr_r7", 3'd7, 32'h0000_000F);

    send(mk(8'h02, 3'd1, 3'd0, 3'd0, 1'b1, 14'h0123), c0);
    send(mk(8'hFF, 3'd1, 3'd0, 3'd0, 1'b1, 14'h0456), c0);
    send(mk(8'h00, 3'd1, 3'd0, 3'd0, 1'b1, 14'h0789), c0);
    dbgchk("ill_r1", 3'd1, 32'h0000_000B);

    send(mk(8'h01, 3'd0, 3'd0, 3'd0, 1'b1, 14'h1234), c0);
    chk("r0_data", wb_data, 32'h0000_1234);
    @(posedge clk); #1;
    chk("r0_once", {31'b0, wb_valid}, 32'd0);
    dbgchk("r0_dbg", 3'd0, 32'd0);

    // ALU_LAT=3 instance: latency, read-before-write, reset mid-WAIT
    instr3 = mk(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 14'h002A);
    instr_valid3 = 1'b1;
    dbg_addr3 = 3'd1;
    @(posedge clk); #1;
    instr_valid3 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("l3_wb_early", {31'b0, wb_valid3}, 32'd0);
    chk("l3_dbg_old", dbg_data3, 32'd0);
    @(posedge clk); #1;
    chk("l3_wb", {31'b0, wb_valid3}, 32'd1);
    chk("l3_data", wb_data3, 32'h0000_002A);
    chk("l3_dbg_new", dbg_data3, 32'h0000_002A);

    instr3 = mk(8'h03, 3'd2, 3'd1, 3'd0, 1'b1, 14'd1);
    instr_valid3 = 1'b1;
    @(posedge clk); #1;
    instr_valid3 = 1'b0;
    @(posedge clk); #1;
    chk("l3_op_wait", {24'b0, alu_op3}, 32'h0000_0003);
    rst3_n = 1'b0;
    #1;
    chk("l3_rst_op", {24'b0, alu_op3}, 32'd0);
    chk("l3_rst_a", alu_a3, 32'd0);
    chk("l3_rst_ready", {31'b0, instr_ready3}, 32'd0);
    chk("l3_rst_r1", dbg_data3, 32'd0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen = seen | wb_valid3;
    end
    chk("l3_no_wb", {31'b0, seen}, 32'd0);
    rst3_n = 1'b1;
    chk("l3_rel_ready0", {31'b0, instr_ready3}, 32'd0);
    @(posedge clk); #1;
    chk("l3_rel_ready1", {31'b0, instr_ready3}, 32'd1);
    dbg_addr3 = 3'd2;
    #1;
    chk("l3_r2", dbg_data3, 32'd0);
    chk("l3_wb_after", {31'b0, wb_valid3}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
